button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Conditions the raw board push-buttons that drive the VM top level. Per
//  button it synchronises the input, debounces it, and emits clean level,
//  press and release strobes, with optional auto-repeat while held.
//  Sits directly upstream of the VM top: btn_press[0] drives go and
//  btn_level[2] drives lock, replacing the raw button wiring.
// PARAMETERS
//  N_BTN       3         number of buttons handled
//  ACTIVE_LOW  1         1: raw pin low = pressed (board keys); 0: high = pressed
//  DB_CYCLES   500000    clocks the input must be stable to accept a change (>=1)
//  REP_DELAY   25000000  clocks held before the first auto-repeat press (>=1)
//  REP_PERIOD  5000000   clocks between later auto-repeat presses (>=1)
//  REP_EN      3'b001    per-button auto-repeat enable mask, width N_BTN
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous, active-high reset
//  btn_raw      in   N_BTN  raw button pins, asynchronous to clk
//  btn_level    out  N_BTN  debounced state, 1 = pressed
//  btn_press    out  N_BTN  one-cycle pulse on accepted press and on each repeat
//  btn_release  out  N_BTN  one-cycle pulse on accepted release
//  any_held     out  1      OR of btn_level
// BEHAVIOUR
//  - The block uses one clock and one reset. The reset is asynchronous and
//    active-high.
//  - Reset: sync flops, counters and outputs are cleared to 0, and every
//    button FSM goes to IDLE. This happens immediately and does not wait
//    for a clock edge.
//  - Input path: polarity is normalised first (pressed = 1). The signal then
//    passes through a 2-flop synchroniser, giving s. Reset clears the
//    synchroniser to the released value.
//  - Each button has an independent FSM {IDLE, PCHK, HELD, RCHK}, a debounce
//    counter dcnt, and a repeat counter rcnt. Counters are sized with
//    $clog2 and never wrap.
//  - IDLE: if s=1, go to PCHK with dcnt=0.
//  - PCHK: if s=0, return to IDLE with no output.
//    Otherwise dcnt increments. On the edge where dcnt==DB_CYCLES-1 and s=1:
//    go to HELD, set btn_level=1, pulse btn_press, and load rcnt=0.
//  - HELD: if s=0, go to RCHK with dcnt=0. While in HELD with REP_EN set,
//    rcnt increments. When rcnt reaches REP_DELAY-1 (first repeat) or
//    REP_PERIOD-1 (later repeats), pulse btn_press and restart rcnt at 0 in
//    period mode. With REP_EN clear, rcnt is frozen at 0.
//  - RCHK: if s=1, return to HELD. rcnt and the delay/period mode are held,
//    not reset, and btn_level stays 1.
//    Otherwise dcnt increments. On the edge where dcnt==DB_CYCLES-1: go to
//    IDLE, set btn_level=0, pulse btn_release, and clear the repeat mode.
//  - Latency (bounce-free press): let E0 be the first edge sampling the
//    pressed raw value. Then s=1 after E1, PCHK is entered at E2, and
//    btn_level/btn_press are high after edge E(DB_CYCLES+2). Release has the
//    same latency.
//  - Outputs are registered. btn_press and btn_release are high for exactly
//    one clock per event and are never high together for the same button.
//  - Buttons are fully independent. Simultaneous presses on several buttons
//    each produce their own pulse in the same cycle.
//  - Bounce shorter than DB_CYCLES produces no strobe and no level change.
//  - Reset mid-operation: no release pulse is emitted. If the button is still
//    held after reset deasserts, it is re-detected as a fresh press after the
//    full latency.
// TESTING
//  (params DB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3, ACTIVE_LOW=1, REP_EN=3'b001)
//  1. btn_raw[1] 1->0 clean, held 20 clk -> btn_level[1] rises and
//     btn_press[1] pulses once after edge E6. No repeats, since REP_EN[1]=0.
//  2. btn_raw[0] bounces 0/1 every 2 clk for 12 clk, then settles to 0 ->
//     no strobe during the bounce. Exactly one btn_press[0], 6 edges after
//     the final transition.
//  3. btn_raw[0] held 40 clk -> first press at E6, repeat 10 clk after
//     entering HELD, then a repeat every 3 clk. Pulse count matches the model.
//  4. Pressed then released cleanly -> btn_release pulses once 6 edges after
//     the release edge and btn_level falls. A 2-clk re-press glitch during
//     RCHK gives no release and no new press.
//  5. rst asserted while btn_level[0]=1 -> all outputs 0 asynchronously with
//     no release pulse. Button still held after rst falls -> btn_press
//     after E6 again.
//  6. Buttons 0 and 2 pressed on the same edge -> btn_press=3'b101 for one
//     cycle and any_held=1. Releasing both -> any_held=0 with btn_release=3'b101.

Source files
------------

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Cleans up raw board push-buttons. Each button is polarity-normalised,
//   brought into the clk domain with a 2-flop synchroniser and debounced by a
//   small per-button FSM. The block produces a clean level, a one-cycle press
//   strobe (also re-issued by auto-repeat while held, where enabled) and a
//   one-cycle release strobe.
//
// Ports
//   clk          in   1      system clock
//   rst          in   1      asynchronous, active-high reset
//   btn_raw      in   N_BTN  raw button pins, asynchronous to clk
//   btn_level    out  N_BTN  debounced state, 1 = pressed
//   btn_press    out  N_BTN  one-cycle pulse on accepted press and each repeat
//   btn_release  out  N_BTN  one-cycle pulse on accepted release
//   any_held     out  1      OR of btn_level
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int               N_BTN      = 3,
  parameter int               ACTIVE_LOW = 1,
  parameter int               DB_CYCLES  = 500000,
  parameter int               REP_DELAY  = 25000000,
  parameter int               REP_PERIOD = 5000000,
  parameter logic [N_BTN-1:0] REP_EN     = 3'b001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_held
);

  // Counter widths; a 1-cycle setting still needs a 1-bit counter.
  localparam int DW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] DEL_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REP_PERIOD - 1);
  localparam logic [DW-1:0] D_ZERO   = {DW{1'b0}};
  localparam logic [DW-1:0] D_ONE    = DW'(1);
  localparam logic [RW-1:0] R_ZERO   = {RW{1'b0}};
  localparam logic [RW-1:0] R_ONE    = RW'(1);
  localparam logic [N_BTN-1:0] B_ZERO = {N_BTN{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // released, waiting for a press
    ST_PCHK = 2'd1,  // press seen, confirming it is stable
    ST_HELD = 2'd2,  // accepted press, auto-repeat running if enabled
    ST_RCHK = 2'd3   // release seen, confirming it is stable
  } state_t;

  // Pressed = 1 from here on, whatever the board wiring.
  logic [N_BTN-1:0] norm_s;
  logic [N_BTN-1:0] sync_meta_r;
  logic [N_BTN-1:0] sync_r;

  state_t        state_r [N_BTN];
  state_t        state_s [N_BTN];
  logic [DW-1:0] dcnt_r  [N_BTN];
  logic [DW-1:0] dcnt_s  [N_BTN];
  logic [RW-1:0] rcnt_r  [N_BTN];
  logic [RW-1:0] rcnt_s  [N_BTN];

  // period_r = 1 once the first repeat has fired (later repeats use REP_PERIOD).
  logic [N_BTN-1:0] period_r;
  logic [N_BTN-1:0] period_s;
  logic [N_BTN-1:0] level_s;
  logic [N_BTN-1:0] press_s;
  logic [N_BTN-1:0] release_s;

  assign norm_s = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  // Two-flop synchroniser; reset value is the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta_r <= B_ZERO;
      sync_r      <= B_ZERO;
    end else begin
      sync_meta_r <= norm_s;
      sync_r      <= sync_meta_r;
    end
  end

  // Per-button debounce / auto-repeat next-state and strobe logic.
  always_comb begin
    logic [RW-1:0] rep_last;
    rep_last  = DEL_LAST;
    period_s  = period_r;
    level_s   = btn_level;
    press_s   = B_ZERO;
    release_s = B_ZERO;
    for (int i = 0; i < N_BTN; i++) begin
      state_s[i] = state_r[i];
      dcnt_s[i]  = dcnt_r[i];
      rcnt_s[i]  = rcnt_r[i];
      rep_last   = period_r[i] ? PER_LAST : DEL_LAST;
      case (state_r[i])
        ST_IDLE: begin
          if (sync_r[i]) begin
            state_s[i] = ST_PCHK;
            dcnt_s[i]  = D_ZERO;
          end else begin
            state_s[i] = ST_IDLE;
          end
        end
        ST_PCHK: begin
          if (!sync_r[i]) begin
            state_s[i] = ST_IDLE;
            dcnt_s[i]  = D_ZERO;
          end else if (dcnt_r[i] == DB_LAST) begin
            state_s[i]  = ST_HELD;
            level_s[i]  = 1'b1;
            press_s[i]  = 1'b1;
            rcnt_s[i]   = R_ZERO;
            period_s[i] = 1'b0;
          end else begin
            dcnt_s[i] = dcnt_r[i] + D_ONE;
          end
        end
        ST_HELD: begin
          if (!sync_r[i]) begin
            // rcnt and repeat mode survive a short release glitch.
            state_s[i] = ST_RCHK;
            dcnt_s[i]  = D_ZERO;
          end else if (REP_EN[i]) begin
            if (rcnt_r[i] == rep_last) begin
              press_s[i]  = 1'b1;
              rcnt_s[i]   = R_ZERO;
              period_s[i] = 1'b1;
            end else begin
              rcnt_s[i] = rcnt_r[i] + R_ONE;
            end
          end else begin
            rcnt_s[i] = R_ZERO;
          end
        end
        ST_RCHK: begin
          if (sync_r[i]) begin
            state_s[i] = ST_HELD;
          end else if (dcnt_r[i] == DB_LAST) begin
            state_s[i]   = ST_IDLE;
            level_s[i]   = 1'b0;
            release_s[i] = 1'b1;
            rcnt_s[i]    = R_ZERO;
            period_s[i]  = 1'b0;
          end else begin
            dcnt_s[i] = dcnt_r[i] + D_ONE;
          end
        end
        default: begin
          state_s[i]  = ST_IDLE;
          dcnt_s[i]   = D_ZERO;
          rcnt_s[i]   = R_ZERO;
          period_s[i] = 1'b0;
          level_s[i]  = 1'b0;
        end
      endcase
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_r[i] <= ST_IDLE;
        dcnt_r[i]  <= D_ZERO;
        rcnt_r[i]  <= R_ZERO;
      end
      period_r    <= B_ZERO;
      btn_level   <= B_ZERO;
      btn_press   <= B_ZERO;
      btn_release <= B_ZERO;
      any_held    <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_r[i] <= state_s[i];
        dcnt_r[i]  <= dcnt_s[i];
        rcnt_r[i]  <= rcnt_s[i];
      end
      period_r    <= period_s;
      btn_level   <= level_s;
      btn_press   <= press_s;
      btn_release <= release_s;
      any_held    <= |level_s;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int         NB   = 3;
  localparam int         DB   = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 3;
  localparam logic [2:0] REN  = 3'b001;
  // Raw change driven just after edge d shows up on the outputs after edge d+LAT.
  localparam int         LAT  = DB + 3;
  localparam int         GAP  = 12;

  logic          clk;
  logic          rst;
  logic [NB-1:0] raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          any_held;

  button_conditioner #(
    .N_BTN(NB), .ACTIVE_LOW(1), .DB_CYCLES(DB),
    .REP_DELAY(RD), .REP_PERIOD(RP), .REP_EN(REN)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .any_held(any_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] press;
    logic [2:0] rel;
  } ev_t;

  typedef struct {
    int btn;
    int hold;
    int exp_press;
    int exp_rel;
  } vec_t;

  ev_t        sb[$];
  int         checks;
  int         errors;
  int         cyc;
  logic [2:0] lvl_exp;
  int         press_seen [NB];
  int         rel_seen   [NB];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Insert an expected event, merging events that fall on the same cycle.
  function automatic void push_ev(input int c, input logic [2:0] p, input logic [2:0] r);
    ev_t e;
    int  k;
    for (k = 0; k < sb.size(); k++) begin
      if (sb[k].cyc == c) begin
        e = sb[k];
        e.press = e.press | p;
        e.rel   = e.rel | r;
        sb[k]   = e;
        return;
      end
      if (sb[k].cyc > c) break;
    end
    e.cyc = c;
    e.press = p;
    e.rel = r;
    sb.insert(k, e);
  endfunction

  task automatic monitor();
    logic [2:0] ep;
    logic [2:0] er;
    ep = 3'b000;
    er = 3'b000;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk("missed_event", cyc, sb[0].cyc);
      sb.delete(0);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      ep = sb[0].press;
      er = sb[0].rel;
      sb.delete(0);
    end
    chk("press", int'(btn_press), int'(ep));
    chk("release", int'(btn_release), int'(er));
    lvl_exp = (lvl_exp | ep) & ~er;
    chk("level", int'(btn_level), int'(lvl_exp));
    chk("any_held", int'(any_held), int'(|lvl_exp));
    for (int i = 0; i < NB; i++) begin
      press_seen[i] += int'(btn_press[i]);
      rel_seen[i]   += int'(btn_release[i]);
    end
  endtask

  // One clock: check outputs at the falling edge, return 1 ns after the rising edge.
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_btn(input int b, input logic pressed);
    raw[b] = ~pressed;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NB; i++) begin
      press_seen[i] = 0;
      rel_seen[i]   = 0;
    end
  endtask

  // Expected events for a clean press held for 'hold' cycles, driven at cycle d.
  task automatic plan_press(input int b, input int d, input int hold);
    logic [2:0] m;
    m = 3'b001 << b;
    if (hold >= DB + 1) begin
      push_ev(d + LAT, m, 3'b000);
      if (REN[b]) begin
        for (int t = d + LAT + RD; t <= d + hold + 2; t += RP) push_ev(t, m, 3'b000);
      end
      push_ev(d + hold + LAT, 3'b000, m);
    end
  endtask

  vec_t vecs [8];

  initial begin
    int d;
    int r;
    vecs[0] = '{btn: 1, hold: 20, exp_press: 1,  exp_rel: 1};  // clean press, no repeat
    vecs[1] = '{btn: 0, hold: 40, exp_press: 10, exp_rel: 1};  // press + 9 repeats
    vecs[2] = '{btn: 2, hold: 12, exp_press: 1,  exp_rel: 1};
    vecs[3] = '{btn: 0, hold: 4,  exp_press: 0,  exp_rel: 0};  // one short of stable
    vecs[4] = '{btn: 0, hold: 5,  exp_press: 1,  exp_rel: 1};  // shortest accepted press
    vecs[5] = '{btn: 0, hold: 15, exp_press: 2,  exp_rel: 1};  // first repeat just fits
    vecs[6] = '{btn: 0, hold: 14, exp_press: 1,  exp_rel: 1};  // first repeat just missed
    vecs[7] = '{btn: 1, hold: 40, exp_press: 1,  exp_rel: 1};  // long hold, repeat disabled

    checks  = 0;
    errors  = 0;
    cyc     = 0;
    lvl_exp = 3'b000;
    clear_counts();
    rst = 1'b1;
    raw = 3'b111;

    @(posedge clk);
    #1;
    chk("reset_level", int'(btn_level), 0);
    chk("reset_press", int'(btn_press), 0);
    chk("reset_release", int'(btn_release), 0);
    chk("reset_any_held", int'(any_held), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    steps(3);

    // Table-driven single-button presses.
    for (int v = 0; v < 8; v++) begin
      clear_counts();
      d = cyc;
      set_btn(vecs[v].btn, 1'b1);
      plan_press(vecs[v].btn, d, vecs[v].hold);
      steps(vecs[v].hold);
      set_btn(vecs[v].btn, 1'b0);
      steps(GAP);
      chk("vec_press_count", press_seen[vecs[v].btn], vecs[v].exp_press);
      chk("vec_release_count", rel_seen[vecs[v].btn], vecs[v].exp_rel);
    end

    // Bounce on button 0: 2-cycle pulses, then settle pressed.
    clear_counts();
    for (int k = 0; k < 3; k++) begin
      set_btn(0, 1'b1);
      steps(2);
      set_btn(0, 1'b0);
      steps(2);
    end
    set_btn(0, 1'b1);
    d = cyc;
    push_ev(d + LAT, 3'b001, 3'b000);
    steps(8);
    set_btn(0, 1'b0);
    push_ev(cyc + LAT, 3'b000, 3'b001);
    steps(GAP);
    chk("bounce_press_count", press_seen[0], 1);

    // Release on button 1 interrupted by a 2-cycle re-press during RCHK.
    clear_counts();
    d = cyc;
    set_btn(1, 1'b1);
    push_ev(d + LAT, 3'b010, 3'b000);
    steps(10);
    set_btn(1, 1'b0);
    steps(2);
    set_btn(1, 1'b1);
    steps(2);
    set_btn(1, 1'b0);
    r = cyc;
    push_ev(r + LAT, 3'b000, 3'b010);
    steps(GAP);
    chk("glitch_press_count", press_seen[1], 1);
    chk("glitch_release_count", rel_seen[1], 1);

    // Reset while button 0 is held: outputs drop at once, then re-detect.
    clear_counts();
    d = cyc;
    set_btn(0, 1'b1);
    push_ev(d + LAT, 3'b001, 3'b000);
    steps(9);
    rst = 1'b1;
    lvl_exp = 3'b000;
    #1;
    chk("rst_async_level", int'(btn_level), 0);
    chk("rst_async_any_held", int'(any_held), 0);
    steps(3);
    rst = 1'b0;
    push_ev(cyc + LAT, 3'b001, 3'b000);
    steps(10);
    set_btn(0, 1'b0);
    push_ev(cyc + LAT, 3'b000, 3'b001);
    steps(GAP);
    chk("rst_press_count", press_seen[0], 2);
    chk("rst_release_count", rel_seen[0], 1);

    // Buttons 0 and 2 pressed and released together.
    clear_counts();
    d = cyc;
    set_btn(0, 1'b1);
    set_btn(2, 1'b1);
    push_ev(d + LAT, 3'b101, 3'b000);
    steps(8);
    set_btn(0, 1'b0);
    set_btn(2, 1'b0);
    push_ev(cyc + LAT, 3'b000, 3'b101);
    steps(GAP);
    chk("dual_press_count", press_seen[0] + press_seen[2], 2);

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
